// File: rtl/clocked_video_rx.sv
// Clocked-video (data/datavalid/v_sync) to Avalon-ST video packets, one packet per frame; 2-cycle latency into an empty FIFO.
// Backpressure is absorbed by the output FIFO; on overflow or a short frame the packet is closed with a dummy eop beat.
module clocked_video_rx #(
    parameter int H_ACTIVE   = 1024,
    parameter int V_ACTIVE   = 768,
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 16,
    parameter bit VSYNC_POL  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] vid_data,
    input  logic              vid_datavalid,
    input  logic              vid_v_sync,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_sop,
    output logic              dout_eop,
    input  logic              clear_status,
    output logic              overflow,
    output logic              short_frame,
    output logic [15:0]       frame_count
);

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [XW-1:0] X_END  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic [DATA_W-1:0] data_q, data_d;
    logic              dv_q, dv_d, dv_d1_q, dv_d1_d;
    logic              vs_q, vs_d, vs_d1_q, vs_d1_d;
    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic              wrote_q, wrote_d;
    logic              flush_fs_q, flush_fs_d;
    logic              fs_en_q, fs_en_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              overflow_q, overflow_d;
    logic              short_frame_q, short_frame_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    beat_t             mem_q [FIFO_DEPTH];

    logic  fs, line_end, full, empty, pop, push, eop_wr, ov_set, sf_set;
    beat_t push_beat, head;

    // Frame start is the trailing edge of the registered v_sync pulse.
    assign fs       = (vs_d1_q == VSYNC_POL) && (vs_q != VSYNC_POL);
    assign line_end = dv_d1_q && !dv_q;

    // Full is judged on the registered pointers only, so a push never relies on a same-cycle pop.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && dout_ready;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign dout_valid  = !empty;
    assign dout_data   = empty ? '0 : head.data;
    assign dout_sop    = !empty && head.sop;
    assign dout_eop    = !empty && head.eop;
    assign overflow    = overflow_q;
    assign short_frame = short_frame_q;
    assign frame_count = frame_count_q;

    always_comb begin
        data_d        = vid_data;
        dv_d          = vid_datavalid;
        vs_d          = vid_v_sync;
        dv_d1_d       = dv_q;
        vs_d1_d       = vs_q;
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        wrote_d       = wrote_q;
        flush_fs_d    = flush_fs_q;
        fs_en_d       = fs_en_q;
        frame_count_d = frame_count_q;
        push          = 1'b0;
        push_beat     = '0;
        eop_wr        = 1'b0;
        ov_set        = 1'b0;
        sf_set        = 1'b0;

        case (state_q)
            IDLE: begin
                if (fs && enable) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    wrote_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (dv_q && x_q != X_END) begin
                    if (full) begin
                        ov_set     = 1'b1;
                        state_d    = FLUSH;
                        flush_fs_d = 1'b0;
                    end else begin
                        push           = 1'b1;
                        push_beat.sop  = (x_q == '0) && (y_q == '0);
                        push_beat.eop  = (x_q == X_LAST) && (y_q == Y_LAST);
                        push_beat.data = data_q;
                        wrote_d        = 1'b1;
                        x_d            = x_q + XW'(1);
                        if (push_beat.eop) begin
                            eop_wr        = 1'b1;
                            frame_count_d = frame_count_q + 16'd1;
                            state_d       = IDLE;
                        end
                    end
                end
                if (line_end) begin
                    x_d = '0;
                    if (x_q != '0) y_d = y_q + YW'(1);
                end
                if (fs) begin
                    if (eop_wr) begin
                        // The completed frame's eop stands; this fs opens the next frame.
                        if (enable) begin
                            state_d = ACTIVE;
                            x_d     = '0;
                            y_d     = '0;
                            wrote_d = 1'b0;
                        end
                    end else if (ov_set) begin
                        flush_fs_d = 1'b1;
                        fs_en_d    = enable;
                    end else if (wrote_q || push) begin
                        sf_set     = 1'b1;
                        state_d    = FLUSH;
                        flush_fs_d = 1'b1;
                        fs_en_d    = enable;
                    end else if (enable) begin
                        x_d = '0;
                        y_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (fs) begin
                    flush_fs_d = 1'b1;
                    fs_en_d    = enable;
                end
                if (!full) begin
                    push          = 1'b1;
                    push_beat.eop = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    if (flush_fs_d && fs_en_d) begin
                        state_d = ACTIVE;
                        x_d     = '0;
                        y_d     = '0;
                        wrote_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        overflow_d    = ov_set || (overflow_q && !clear_status);
        short_frame_d = sf_set || (short_frame_q && !clear_status);
        wr_ptr_d      = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q        <= '0;
            dv_q          <= 1'b0;
            vs_q          <= 1'b0;
            dv_d1_q       <= 1'b0;
            vs_d1_q       <= 1'b0;
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            wrote_q       <= 1'b0;
            flush_fs_q    <= 1'b0;
            fs_en_q       <= 1'b0;
            frame_count_q <= '0;
            overflow_q    <= 1'b0;
            short_frame_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            data_q        <= data_d;
            dv_q          <= dv_d;
            vs_q          <= vs_d;
            dv_d1_q       <= dv_d1_d;
            vs_d1_q       <= vs_d1_d;
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            wrote_q       <= wrote_d;
            flush_fs_q    <= flush_fs_d;
            fs_en_q       <= fs_en_d;
            frame_count_q <= frame_count_d;
            overflow_q    <= overflow_d;
            short_frame_q <= short_frame_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset: outputs are gated by empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_beat;
    end

endmodule

// File: doc/clocked_video_rx.md
Name: clocked_video_rx

Overview:
- Receives a clocked-video stream and repacks it as an Avalon-ST video stream. The input uses the same signalling that the video output drives to the VGA DAC: pixel data, datavalid, h_sync and v_sync.
- Sits between an external or looped-back video source and the frame-buffer writer in the FPGA fabric.
- Each captured frame becomes one packet, marked with sop and eop.
- A small FIFO absorbs downstream backpressure. Overflow and short frames are flagged, and both still produce well-formed packets.

Parameters:
- H_ACTIVE, 1024, active pixels per line.
- V_ACTIVE, 768, active lines per frame.
- DATA_W, 24, pixel width, packed {r,g,b}.
- FIFO_DEPTH, 16, output FIFO entries; must be a power of 2 and at least 4.
- VSYNC_POL, 0, v_sync active level (0 = active-low).

Ports:
- clk  in  1  single clock; vid_* inputs and the Avalon-ST output are both synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable; sampled only at frame start.
- vid_data  in  DATA_W  pixel data.
- vid_datavalid  in  1  active-pixel qualifier.
- vid_v_sync  in  1  vertical sync, polarity set by VSYNC_POL.
- dout_data  out  DATA_W  Avalon-ST pixel data.
- dout_valid  out  1  Avalon-ST valid.
- dout_ready  in  1  Avalon-ST ready; ready latency 0.
- dout_sop  out  1  first pixel of the frame.
- dout_eop  out  1  last pixel of the frame.
- clear_status  in  1  one-cycle pulse that clears the sticky flags.
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- short_frame  out  1  sticky: v_sync arrived before the frame was complete.
- frame_count  out  16  count of eops written to the FIFO; wraps at 0xFFFF to 0.

Behaviour:
- Reset: all outputs are 0, the FIFO is empty, the state is IDLE, counters are 0, and the input registers are 0.
- Input stage: vid_* is registered once. The frame-start event fs is the cycle where the registered v_sync goes from its active level to its inactive level.
- Line end: the cycle where the registered datavalid goes 1 to 0.
- Counters:
  - x counts 0..H_ACTIVE-1 and y counts 0..V_ACTIVE-1.
  - x clears at every line end; y increments at every line end only if x != 0.
  - While x == H_ACTIVE, further pixels in that line are discarded without error.
- States:
  - IDLE: on fs with enable=1, go to ACTIVE and clear x and y; enable=0 stays IDLE.
  - ACTIVE: for each registered pixel, write {sop=(x==0&&y==0), eop=(x==H_ACTIVE-1&&y==V_ACTIVE-1), data}.
    - After the eop write, go to IDLE and increment frame_count.
    - FIFO full on a pixel: drop it, set overflow, go to FLUSH.
    - fs before eop (and after at least one pixel was written): set short_frame, go to FLUSH.
    - fs with no pixel yet written: restart the frame in place.
  - FLUSH: on the first cycle the FIFO is not full, write a dummy entry {sop=0, eop=1, data=0}, increment frame_count, go to IDLE.
    - If FLUSH was entered on fs and enable=1, go to ACTIVE instead, with x and y cleared.
    - Pixels arriving while in FLUSH are discarded.
- Simultaneous eop write and fs: the eop is written normally, frame_count increments, and the fs is treated as the start of the next frame.
- FIFO:
  - Show-ahead: dout_* reflects the head entry, and dout_valid = !empty.
  - A pop happens when dout_valid && dout_ready.
  - A write to a full FIFO is never performed.
  - A simultaneous push and pop while full is not allowed: a push into a full FIFO is always treated as overflow.
  - dout_data, dout_sop and dout_eop hold steady while dout_valid=1 and dout_ready=0.
- Latency: a pixel on vid_* at cycle N appears on dout with dout_valid=1 at N+2, given an empty FIFO.
- Sticky flags: set on their event; clear_status clears them; if set and clear happen in the same cycle, set wins.
- Reset mid-frame: everything returns to reset values immediately, and partial FIFO contents are lost.

Test Plan (H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=4, dout_ready=1 unless noted):
- Nominal frame: enable=1, fs, then 2 lines of 4 pixels 0x000001..0x000008 -> 8 beats, sop on 0x000001, eop on 0x000008, frame_count=1, first beat 2 cycles after its input.
- Backpressure: dout_ready held 0 during the frame -> first 4 pixels are held (0x000001 at head), overflow=1. After ready=1: beats 1..4, then dummy eop with data 0; frame_count=1.
- Short frame: fs after 5 pixels -> 5 beats, then dummy eop; short_frame=1; the next full frame is captured intact with sop.
- Long line: 6 pixels in line 0 -> pixels 5 and 6 dropped, no flag; line 1 starts at x=0; eop on the 8th accepted pixel.
- Enable gating and reset: enable=0 at fs -> no beats, frame_count stays 0. Assert reset mid-frame -> dout_valid=0 immediately and all flags and counters are 0.
- Status clear: overflow=1, then a clear_status pulse -> overflow=0. A clear coinciding with a new overflow event -> overflow stays 1.
